// File: rtl/seg7_modcount_gen.sv
// rtl/seg7_modcount_gen.sv - modulo up/down counter with prescaler, load, terminal-count pulse and 7-segment decode
module seg7_modcount_gen #(
    parameter int WIDTH          = 4,
    parameter int MODULUS        = 10,
    parameter int DIV_W          = 7,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tc_q, tc_d;

    logic [2:0]       sel_s;
    logic [DIV_W-1:0] tick_mask;
    logic             tick;
    logic [3:0]       count4;
    logic [6:0]       seg_raw;
    logic             unused_ok;

    assign unused_ok = ^uio_in;

    always_comb begin
        sel_s = ui_in[5:3];
        if (int'(sel_s) > DIV_W) begin
            sel_s = 3'(DIV_W);
        end
        // An all-zero mask (s == 0) makes every cycle a tick.
        for (int i = 0; i < DIV_W; i++) begin
            tick_mask[i] = (i < int'(sel_s));
        end
        tick = ((div_q & tick_mask) == tick_mask);

        count_d = count_q;
        div_d   = div_q;
        tc_d    = 1'b0;
        if (ena) begin
            div_d = div_q + DIV_W'(1);
            if (ui_in[2]) begin
                count_d = (uio_in[WIDTH-1:0] > MAX_CNT) ? MAX_CNT : uio_in[WIDTH-1:0];
            end else if (ui_in[0] && tick) begin
                if (!ui_in[1]) begin
                    if (count_q == MAX_CNT) begin
                        count_d = '0;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        count_d = MAX_CNT;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            div_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            div_q   <= div_d;
            tc_q    <= tc_d;
        end
    end

    always_comb begin
        count4             = '0;
        count4[WIDTH-1:0]  = count_q;
        case (count4)
            4'h0:    seg_raw = 7'h3F;
            4'h1:    seg_raw = 7'h06;
            4'h2:    seg_raw = 7'h5B;
            4'h3:    seg_raw = 7'h4F;
            4'h4:    seg_raw = 7'h66;
            4'h5:    seg_raw = 7'h6D;
            4'h6:    seg_raw = 7'h7D;
            4'h7:    seg_raw = 7'h07;
            4'h8:    seg_raw = 7'h7F;
            4'h9:    seg_raw = 7'h6F;
            4'hA:    seg_raw = 7'h77;
            4'hB:    seg_raw = 7'h7C;
            4'hC:    seg_raw = 7'h39;
            4'hD:    seg_raw = 7'h5E;
            4'hE:    seg_raw = 7'h79;
            default: seg_raw = 7'h71;
        endcase
    end

    assign uo_out[6:0] = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    assign uo_out[7]   = ui_in[6] ? tc_q : ui_in[7];
    assign uio_out     = {count4, 4'b0000};
    assign uio_oe      = 8'hF0;

endmodule

// File: tb/tb_seg7_modcount_gen.sv
// tb/tb_seg7_modcount_gen.sv - scoreboard bench for seg7_modcount_gen
module tb_seg7_modcount_gen;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;
    logic [7:0] uo_out_al, uio_out_al, uio_oe_al;

    typedef struct {
        logic [3:0] cnt;
        logic       tc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mdiv     = 0;

    logic [6:0] hex_map [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_modcount_gen dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    seg7_modcount_gen #(.SEG_ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out_al), .uio_out(uio_out_al), .uio_oe(uio_oe_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clk_edge();
        @(posedge clk);
        if (!rst_n) mdiv = 0;
        else if (ena) mdiv = (mdiv + 1) % 128;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        clk_edge();
        clk_edge();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (uo_out !== 8'h3F) begin
            n_fail++; $display("FAIL reset_uo_out got %h want 3f", uo_out);
        end
        n_checks++;
        if (uio_out !== 8'h00) begin
            n_fail++; $display("FAIL reset_uio_out got %h want 00", uio_out);
        end
        n_checks++;
        if (uio_oe !== 8'hF0 || uio_oe_al !== 8'hF0) begin
            n_fail++; $display("FAIL reset_uio_oe got %h/%h want f0", uio_oe, uio_oe_al);
        end
        n_checks++;
        if (uo_out_al[6:0] !== 7'h40 || uio_out_al !== 8'h00) begin
            n_fail++; $display("FAIL reset_active_low got %h/%h want 40/00", uo_out_al[6:0], uio_out_al);
        end
    endtask

    task automatic test_count_up();
        ui_in = 8'h41;
        for (int k = 1; k <= 12; k++) begin
            sb.push_back('{cnt: 4'(k % 10), tc: (k == 10)});
            clk_edge();
            e = sb.pop_front();
            n_checks++;
            if (uio_out[7:4] !== e.cnt || uo_out[6:0] !== hex_map[e.cnt]) begin
                n_fail++;
                $display("FAIL count_up edge %0d count/seg got %0d/%h want %0d/%h",
                         k, uio_out[7:4], uo_out[6:0], e.cnt, hex_map[e.cnt]);
            end
            n_checks++;
            if (uo_out[7] !== e.tc) begin
                n_fail++; $display("FAIL count_up_tc edge %0d got %b want %b", k, uo_out[7], e.tc);
            end
        end
    endtask

    task automatic test_count_down();
        rst_n = 1'b0; ui_in = 8'h00;
        clk_edge();
        rst_n = 1'b1; ui_in = 8'h43;
        for (int k = 1; k <= 3; k++) begin
            sb.push_back('{cnt: 4'(10 - k), tc: (k == 1)});
            clk_edge();
            e = sb.pop_front();
            n_checks++;
            if (uio_out[7:4] !== e.cnt || uo_out[6:0] !== hex_map[e.cnt] || uo_out[7] !== e.tc) begin
                n_fail++;
                $display("FAIL count_down edge %0d count/seg/tc got %0d/%h/%b want %0d/%h/%b",
                         k, uio_out[7:4], uo_out[6:0], uo_out[7], e.cnt, hex_map[e.cnt], e.tc);
            end
        end
    endtask

    task automatic test_load();
        logic [7:0] ld_ui  [4] = '{8'h44, 8'h45, 8'h44, 8'h45};
        logic [7:0] ld_val [4] = '{8'h0C, 8'h05, 8'hF3, 8'h09};
        logic [3:0] ld_exp [4] = '{4'd9, 4'd5, 4'd3, 4'd9};
        for (int k = 0; k < 4; k++) begin
            ui_in = ld_ui[k]; uio_in = ld_val[k];
            sb.push_back('{cnt: ld_exp[k], tc: 1'b0});
            clk_edge();
            e = sb.pop_front();
            n_checks++;
            if (uio_out[7:4] !== e.cnt || uo_out[7] !== e.tc) begin
                n_fail++;
                $display("FAIL load %0d count/tc got %0d/%b want %0d/%b",
                         k, uio_out[7:4], uo_out[7], e.cnt, e.tc);
            end
        end
        // Load at count 9 with count enabled must not wrap or raise tc.
        ui_in = 8'h45; uio_in = 8'h07;
        sb.push_back('{cnt: 4'd7, tc: 1'b0});
        clk_edge();
        e = sb.pop_front();
        n_checks++;
        if (uio_out[7:4] !== e.cnt || uo_out[7] !== e.tc) begin
            n_fail++;
            $display("FAIL load_over_wrap count/tc got %0d/%b want %0d/%b", uio_out[7:4], uo_out[7], e.cnt, e.tc);
        end
        ui_in = 8'h00;
    endtask

    task automatic test_prescaler();
        rst_n = 1'b0; ui_in = 8'h00;
        clk_edge();
        rst_n = 1'b1; ui_in = 8'h59;
        for (int k = 1; k <= 29; k++) begin
            ena = !(k > 20 && k <= 25);
            if (k <= 20)      sb.push_back('{cnt: 4'(k / 8), tc: 1'b0});
            else if (k <= 25) sb.push_back('{cnt: 4'd2, tc: 1'b0});
            else              sb.push_back('{cnt: (k == 29) ? 4'd3 : 4'd2, tc: 1'b0});
            clk_edge();
            e = sb.pop_front();
            n_checks++;
            if (uio_out[7:4] !== e.cnt || uo_out[7] !== e.tc) begin
                n_fail++;
                $display("FAIL prescaler edge %0d count/tc got %0d/%b want %0d/%b",
                         k, uio_out[7:4], uo_out[7], e.cnt, e.tc);
            end
        end
        ena = 1'b1;
    endtask

    task automatic test_enable_tc();
        logic       en_seq [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] ui_seq [4] = '{8'h44, 8'h41, 8'h41, 8'h41};
        logic [3:0] c_exp  [4] = '{4'd9, 4'd0, 4'd0, 4'd1};
        logic       t_exp  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        uio_in = 8'h09;
        for (int k = 0; k < 4; k++) begin
            ena = en_seq[k]; ui_in = ui_seq[k];
            sb.push_back('{cnt: c_exp[k], tc: t_exp[k]});
            clk_edge();
            e = sb.pop_front();
            n_checks++;
            if (uio_out[7:4] !== e.cnt || uo_out[7] !== e.tc) begin
                n_fail++;
                $display("FAIL enable_tc step %0d count/tc got %0d/%b want %0d/%b",
                         k, uio_out[7:4], uo_out[7], e.cnt, e.tc);
            end
        end
        ena = 1'b1;
    endtask

    task automatic test_mode_polarity();
        ui_in = 8'h80;
        #1;
        n_checks++;
        if (uo_out[7] !== 1'b1) begin
            n_fail++; $display("FAIL dp_passthrough_hi got %b want 1", uo_out[7]);
        end
        ui_in = 8'h00;
        #1;
        n_checks++;
        if (uo_out[7] !== 1'b0) begin
            n_fail++; $display("FAIL dp_passthrough_lo got %b want 0", uo_out[7]);
        end
        ui_in = 8'h04; uio_in = 8'h08;
        clk_edge();
        ui_in = 8'h00;
        n_checks++;
        if (uo_out_al[6:0] !== 7'h00 || uo_out[6:0] !== 7'h7F) begin
            n_fail++;
            $display("FAIL polarity_at_8 got %h/%h want 00/7f", uo_out_al[6:0], uo_out[6:0]);
        end
    endtask

    task automatic test_reset_mid_count();
        ui_in = 8'h04; uio_in = 8'h07;
        clk_edge();
        ui_in = 8'h00;
        if (mdiv % 2 == 0) clk_edge();
        rst_n = 1'b0; ui_in = 8'h45; uio_in = 8'h03;
        sb.push_back('{cnt: 4'd0, tc: 1'b0});
        clk_edge();
        e = sb.pop_front();
        n_checks++;
        if (uio_out !== 8'h00 || uo_out[7] !== e.tc || uo_out[6:0] !== hex_map[e.cnt]) begin
            n_fail++;
            $display("FAIL reset_mid uio_out/tc/seg got %h/%b/%h want 00/0/3f", uio_out, uo_out[7], uo_out[6:0]);
        end
        // With div cleared, s=1 needs two edges for the first tick.
        rst_n = 1'b1; ui_in = 8'h49;
        for (int k = 1; k <= 2; k++) begin
            sb.push_back('{cnt: 4'(k - 1), tc: 1'b0});
            clk_edge();
            e = sb.pop_front();
            n_checks++;
            if (uio_out[7:4] !== e.cnt || uo_out[7] !== e.tc) begin
                n_fail++;
                $display("FAIL reset_mid_div edge %0d count/tc got %0d/%b want %0d/%b",
                         k, uio_out[7:4], uo_out[7], e.cnt, e.tc);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_prescaler();
        test_enable_tc();
        test_mode_polarity();
        test_reset_mid_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_modcount_gen.md
Name: seg7_modcount_gen

Overview:
- Parametrised successor to the fixed 3-bit free-running counter with 7-segment decode.
- Adds configurable modulus and width, a programmable power-of-two prescaler, up/down counting, synchronous parallel load, a terminal-count pulse and a selectable segment polarity.
- Sits at the Tiny Tapeout user-module boundary and drives a single 7-segment digit plus decimal point.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1..4.
- MODULUS, 10, count range 0..MODULUS-1; legal range 2..2^WIDTH.
- DIV_W, 7, prescaler width in bits; legal range 1..7.
- SEG_ACTIVE_LOW, 0, when 1, uo_out[6:0] is inverted for common-anode displays.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- ena  in  1  design enable; 0 freezes all state.
- ui_in  in  8  [0] count enable, [1] direction (0 up, 1 down), [2] load strobe, [5:3] prescaler select, [6] uo_out[7] mode, [7] decimal-point input.
- uio_in  in  8  [WIDTH-1:0] load value; remaining bits ignored.
- uo_out  out  8  [6:0] segments a..g (bit0 = a), [7] decimal point or terminal-count pulse, chosen by ui_in[6].
- uio_out  out  8  [7:4] count, zero-extended to 4 bits; [3:0] tied to 0.
- uio_oe  out  8  constant 8'hF0.

Behaviour:
- Reset (rst_n=0 at a clk edge): count=0, div=0, tc=0.
  - Outputs after reset: uo_out[6:0]=7'h3F (inverted when SEG_ACTIVE_LOW=1), uio_out=8'h00.
- ena=0: count and div hold their values; tc is cleared to 0 on the next edge. Outputs are still driven from the held state.
- Prescaler:
  - div is a DIV_W-bit free-running incrementer while ena=1, wrapping modulo 2^DIV_W.
  - s = min(ui_in[5:3], DIV_W).
  - tick = 1 when s==0; otherwise tick = 1 when div[s-1:0] is all ones.
  - The resulting tick period is 2^s cycles.
  - Load does not clear div.
- Counter priority per edge (ena=1):
  1. Load: if ui_in[2]=1, count <= min(uio_in[WIDTH-1:0], MODULUS-1) and tc <= 0. Load is not gated by tick or ui_in[0].
  2. Count: else if ui_in[0]=1 and tick=1:
     - up: count==MODULUS-1 -> count <= 0, tc <= 1; otherwise count+1, tc <= 0.
     - down: count==0 -> count <= MODULUS-1, tc <= 1; otherwise count-1, tc <= 0.
  3. Hold: otherwise count holds and tc <= 0.
- tc is a registered pulse, high for exactly one cycle after the wrapping edge. With s=0 and continuous enable, tc is high once every MODULUS cycles.
- Direction change takes effect on the next tick; no extra cycles are inserted.
- Segment decode is combinational from registered count, so the display updates in the same cycle count changes.
  - Hex map 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- uo_out[7] = ui_in[7] when ui_in[6]=0, and tc when ui_in[6]=1. This path is combinational.
- Reset asserted mid-count overrides load and count on the same edge.
- Legality: with a legal MODULUS, the counter is never outside 0..MODULUS-1.

Test Plan:
1. Reset, defaults, ui_in=8'h01 (up, s=0) for 12 cycles -> count 0..9,0,1; uo_out[6:0] 3F,06,...,6F,3F; tc high only in the cycle after 9->0.
2. Down from reset, ui_in=8'h03 -> first edge count=9, tc=1 for one cycle; next edges 8,7.
3. Load: uio_in=4'hC, ui_in[2]=1 for one cycle (MODULUS=10) -> count=9 (saturated). Then load 4'h5 with ui_in[0]=1 -> count=5, with load winning over count.
4. Prescaler: ui_in[5:3]=3, up counting -> count advances once every 8 cycles. Dropping ena=0 for 5 cycles freezes count and div; tc=0 throughout.
5. Mode/polarity: ui_in[6]=0, ui_in[7]=1 -> uo_out[7]=1. With ui_in[6]=1, uo_out[7] mirrors tc. With SEG_ACTIVE_LOW=1 at count=8 -> uo_out[6:0]=7'h00.
6. Reset mid-count at count=7 with load asserted -> next cycle count=0, div=0, tc=0; uio_out=8'h00.
